pll_dcfg_ctrl: RTL and testbench



---
 rtl/pll_dcfg_ctrl_if.sv | 22 ++
 rtl/pll_dcfg_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_pll_dcfg_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_dcfg_ctrl_if.sv
// Request/response bus between the system-side register bank and the
// EF2 PLL dynamic-configuration initiator.
interface pll_dcfg_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_cmd;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;

  modport master (
    output req_valid, req_cmd, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_cmd, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/pll_dcfg_ctrl.sv
// EF2 PLL dynamic-configuration initiator: turns single-beat register requests
// into dclk/dcs/dwe port cycles and sequences PLL reset/relock with a lock timeout.
module pll_dcfg_ctrl #(
  parameter int DCLK_DIV     = 2,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  pll_dcfg_ctrl_if.slave        bus,
  output logic                  locked,
  output logic                  pll_reset,
  output logic                  pll_dclk,
  output logic                  pll_dcs,
  output logic                  pll_dwe,
  output logic [5:0]            pll_daddr,
  output logic [7:0]            pll_di,
  input  logic [7:0]            pll_do,
  input  logic                  pll_extlock
);

  localparam int PW = $clog2(DCLK_DIV + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);

  localparam logic [PW-1:0] PH_LAST  = PW'(DCLK_DIV - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    PWRUP_RST  = 3'd0,
    LOCK_WAIT  = 3'd1,
    IDLE       = 3'd2,
    SETUP      = 3'd3,
    STROBE     = 3'd4,
    TAIL       = 3'd5,
    RD_HIGH    = 3'd6,
    RST_ASSERT = 3'd7
  } state_t;

  state_t        state_r;
  logic [PW-1:0] ph_cnt_r;
  logic [TW-1:0] tmo_cnt_r;
  logic [RW-1:0] rst_cnt_r;
  logic          is_read_r;
  logic          relock_rsp_r;
  logic          ext_meta_r;
  logic          ext_sync_r;

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_meta_r <= 1'b0;
      ext_sync_r <= 1'b0;
    end else begin
      ext_meta_r <= pll_extlock;
      ext_sync_r <= ext_meta_r;
    end
  end

  // Sequencer: power-up/relock reset, lock wait, and configuration-port access phases.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= PWRUP_RST;
      ph_cnt_r      <= PW'(1'b0);
      tmo_cnt_r     <= TW'(1'b0);
      rst_cnt_r     <= RW'(1'b0);
      is_read_r     <= 1'b0;
      relock_rsp_r  <= 1'b0;
      locked        <= 1'b0;
      pll_reset     <= 1'b1;
      pll_dclk      <= 1'b0;
      pll_dcs       <= 1'b0;
      pll_dwe       <= 1'b0;
      pll_daddr     <= 6'h00;
      pll_di        <= 8'h00;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 8'h00;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state_r)
        PWRUP_RST, RST_ASSERT: begin
          if (rst_cnt_r == RST_LAST) begin
            state_r   <= LOCK_WAIT;
            pll_reset <= 1'b0;
            tmo_cnt_r <= TW'(1'b0);
          end else begin
            rst_cnt_r <= rst_cnt_r + RW'(1'b1);
          end
        end
        // Only a relock request owes a response; power-up exits silently.
        LOCK_WAIT: begin
          if (ext_sync_r) begin
            state_r       <= IDLE;
            locked        <= 1'b1;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= relock_rsp_r;
            bus.rsp_err   <= 1'b0;
          end else if (tmo_cnt_r == TMO_LAST) begin
            state_r       <= IDLE;
            locked        <= 1'b0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= relock_rsp_r;
            bus.rsp_err   <= 1'b1;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1'b1);
          end
        end
        IDLE: begin
          locked <= ext_sync_r;
          if (bus.req_valid && bus.req_ready) begin
            case (bus.req_cmd)
              2'b00, 2'b01: begin
                state_r       <= SETUP;
                bus.req_ready <= 1'b0;
                ph_cnt_r      <= PW'(1'b0);
                is_read_r     <= ~bus.req_cmd[0];
                pll_dcs       <= 1'b1;
                pll_dwe       <= bus.req_cmd[0];
                pll_daddr     <= bus.req_addr;
                pll_di        <= bus.req_wdata;
              end
              2'b10: begin
                state_r       <= RST_ASSERT;
                bus.req_ready <= 1'b0;
                rst_cnt_r     <= RW'(1'b0);
                relock_rsp_r  <= 1'b1;
                pll_reset     <= 1'b1;
                locked        <= 1'b0;
              end
              default: begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_err   <= 1'b1;
              end
            endcase
          end
        end
        SETUP: begin
          locked <= ext_sync_r;
          if (ph_cnt_r == PH_LAST) begin
            state_r  <= STROBE;
            ph_cnt_r <= PW'(1'b0);
            pll_dclk <= 1'b1;
          end else begin
            ph_cnt_r <= ph_cnt_r + PW'(1'b1);
          end
        end
        STROBE: begin
          locked <= ext_sync_r;
          if (ph_cnt_r == PH_LAST) begin
            state_r  <= TAIL;
            ph_cnt_r <= PW'(1'b0);
            pll_dclk <= 1'b0;
            pll_dcs  <= 1'b0;
            pll_dwe  <= 1'b0;
          end else begin
            ph_cnt_r <= ph_cnt_r + PW'(1'b1);
          end
        end
        TAIL: begin
          locked <= ext_sync_r;
          if (ph_cnt_r == PH_LAST) begin
            ph_cnt_r <= PW'(1'b0);
            if (is_read_r) begin
              state_r  <= RD_HIGH;
              pll_dclk <= 1'b1;
            end else begin
              state_r       <= IDLE;
              bus.req_ready <= 1'b1;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b0;
            end
          end else begin
            ph_cnt_r <= ph_cnt_r + PW'(1'b1);
          end
        end
        RD_HIGH: begin
          locked <= ext_sync_r;
          if (ph_cnt_r == PH_LAST) begin
            state_r       <= IDLE;
            ph_cnt_r      <= PW'(1'b0);
            pll_dclk      <= 1'b0;
            bus.rsp_rdata <= pll_do;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
          end else begin
            ph_cnt_r <= ph_cnt_r + PW'(1'b1);
          end
        end
        default: begin
          state_r       <= PWRUP_RST;
          rst_cnt_r     <= RW'(1'b0);
          relock_rsp_r  <= 1'b0;
          pll_reset     <= 1'b1;
          pll_dclk      <= 1'b0;
          pll_dcs       <= 1'b0;
          pll_dwe       <= 1'b0;
          locked        <= 1'b0;
          bus.req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_dcfg_ctrl.sv
// Scoreboard bench for pll_dcfg_ctrl: directed requests push expected responses,
// a negedge monitor pops and compares whenever rsp_valid is seen.
module tb_pll_dcfg_ctrl;

  logic       clk;
  logic       rst;
  logic       locked, pll_reset, pll_dclk, pll_dcs, pll_dwe;
  logic [5:0] pll_daddr;
  logic [7:0] pll_di;
  logic [7:0] pll_do;
  logic       pll_extlock;

  pll_dcfg_ctrl_if bus();

  pll_dcfg_ctrl #(
    .DCLK_DIV    (2),
    .RST_CYCLES  (16),
    .LOCK_TIMEOUT(1000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .locked     (locked),
    .pll_reset  (pll_reset),
    .pll_dclk   (pll_dclk),
    .pll_dcs    (pll_dcs),
    .pll_dwe    (pll_dwe),
    .pll_daddr  (pll_daddr),
    .pll_di     (pll_di),
    .pll_do     (pll_do),
    .pll_extlock(pll_extlock)
  );

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   n;
  int   dcs_cnt, dwe_cnt, rise_cnt, rise_cs_cnt, dclk_hi_cnt;
  logic [5:0] seen_addr;
  logic [7:0] seen_di;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // PLL configuration port model: read data appears only while dclk is high with dcs low.
  initial begin
    pll_do = 8'hFF;
    forever begin
      @(negedge clk);
      pll_do = (pll_dclk && !pll_dcs) ? 8'h3C : 8'hFF;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("rsp_err", bus.rsp_err, mon_e.err);
        chk("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
        chk("rsp_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic issue(input logic [1:0] c, input logic [5:0] a, input logic [7:0] d,
                       input logic [7:0] er, input logic ee, input int lat, input bit push);
    int w = 0;
    while (!bus.req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready", bus.req_ready, 1'b1);
    bus.req_cmd   = c;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_valid = 1'b1;
    if (push) sb_q.push_back('{er, ee, cyc + 1 + lat});
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic observe(input int ncyc);
    logic prev = 1'b0;
    dcs_cnt = 0; dwe_cnt = 0; rise_cnt = 0; rise_cs_cnt = 0; dclk_hi_cnt = 0;
    seen_addr = 6'h00; seen_di = 8'h00;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (pll_dcs) begin
        if (dcs_cnt == 0) begin
          seen_addr = pll_daddr;
          seen_di   = pll_di;
        end
        dcs_cnt++;
      end
      if (pll_dwe) dwe_cnt++;
      if (pll_dclk) dclk_hi_cnt++;
      if (pll_dclk && !prev) begin
        rise_cnt++;
        if (pll_dcs) rise_cs_cnt++;
      end
      prev = pll_dclk;
    end
  endtask

  task automatic measure_rst(output int cnt);
    cnt = 0;
    while (pll_reset && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic wait_drain(input int bound);
    int w = 0;
    while (sb_q.size() != 0 && w < bound) begin
      @(negedge clk);
      w++;
    end
    chk("drain_pending", sb_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_cmd   = 2'b00;
    bus.req_addr  = 6'h00;
    bus.req_wdata = 8'h00;
    pll_extlock   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pll_reset", pll_reset, 1'b1);
    chk("rst_outputs", {locked, pll_dclk, pll_dcs, pll_dwe, bus.req_ready, bus.rsp_valid,
                        pll_daddr, pll_di, bus.rsp_rdata}, 64'd0);

    // Power-up
    rst = 1'b0;
    measure_rst(n);
    chk("pwrup_reset_len", n, 16);
    repeat (49) @(negedge clk);
    pll_extlock = 1'b1;
    n = 0;
    while (!locked && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("lock_latency", n, 3);
    chk("ready_after_lock", bus.req_ready, 1'b1);

    // Write 0x12 <- 0xA5
    issue(2'b01, 6'h12, 8'hA5, 8'h00, 1'b0, 6, 1'b1);
    observe(10);
    chk("wr_dcs_cycles", dcs_cnt, 4);
    chk("wr_dwe_cycles", dwe_cnt, 4);
    chk("wr_dclk_rise_in_cs", rise_cs_cnt, 1);
    chk("wr_daddr", seen_addr, 6'h12);
    chk("wr_di", seen_di, 8'hA5);
    chk("wr_daddr_hold", pll_daddr, 6'h12);

    // Read 0x05
    issue(2'b00, 6'h05, 8'h00, 8'h3C, 1'b0, 8, 1'b1);
    observe(10);
    chk("rd_dwe_never", dwe_cnt, 0);
    chk("rd_dcs_cycles", dcs_cnt, 4);
    chk("rd_dclk_rises", rise_cnt, 2);
    chk("rd_daddr", seen_addr, 6'h05);

    // Loss of lock while idle
    pll_extlock = 1'b0;
    repeat (4) @(negedge clk);
    chk("lock_loss", locked, 1'b0);

    // Relock with extlock held low: timeout
    issue(2'b10, 6'h00, 8'h00, 8'h3C, 1'b1, 1016, 1'b1);
    @(negedge clk);
    measure_rst(n);
    chk("relock_reset_len", n, 16);
    chk("relock_locked_low", locked, 1'b0);
    wait_drain(1100);
    chk("timeout_locked", locked, 1'b0);

    // Relock with extlock rising right after pll_reset falls
    issue(2'b10, 6'h00, 8'h00, 8'h3C, 1'b0, 19, 1'b1);
    @(negedge clk);
    measure_rst(n);
    chk("relock2_reset_len", n, 16);
    pll_extlock = 1'b1;
    wait_drain(50);
    chk("relock2_locked", locked, 1'b1);

    // Illegal command
    issue(2'b11, 6'h3F, 8'hFF, 8'h3C, 1'b1, 0, 1'b1);
    observe(4);
    chk("ill_dcs", dcs_cnt, 0);
    chk("ill_dclk", dclk_hi_cnt, 0);
    chk("ill_ready", bus.req_ready, 1'b1);

    // Reset during STROBE of a read: no response, power-up restarts
    issue(2'b00, 6'h09, 8'h00, 8'h00, 1'b0, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("strobe_dclk_before_rst", pll_dclk, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_dcs", pll_dcs, 1'b0);
    chk("abort_dclk", pll_dclk, 1'b0);
    chk("abort_pll_reset", pll_reset, 1'b1);
    chk("abort_rdata_cleared", bus.rsp_rdata, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    measure_rst(n);
    chk("restart_reset_len", n, 16);
    @(negedge clk);
    chk("restart_locked", locked, 1'b1);
    chk("restart_ready", bus.req_ready, 1'b1);

    repeat (5) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
